// File: rtl/mem_map_pkg.sv
// Memory map constants and shared types for the system write port arbiter.
package mem_map_pkg;

    // Region is taken from the top address nibble.
    localparam logic [3:0]  REGION_SRAM    = 4'h0;
    localparam logic [3:0]  REGION_VRAM    = 4'h8;
    localparam logic [3:0]  REGION_CTRL    = 4'hF;
    localparam int unsigned REGION_MSB     = 15;
    localparam int unsigned REGION_LSB     = 12;
    localparam int unsigned BANK_SEL_BIT   = 8;
    localparam int unsigned CTRL_RESET_BIT = 0;

    // Which requester owns the write port this cycle.
    typedef enum logic [1:0] {
        GntNone,
        GntDbg,
        GntCpu
    } grant_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; a push into a full FIFO is accepted when a pop happens in the same cycle.
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign full_o    = (r_count == FULL_CNT);
    assign empty_o   = (r_count == '0);
    assign w_do_pop  = pop_i & ~empty_o;
    // When full, the slot being written is the one being read out this cycle.
    assign w_do_push = push_i & (~full_o | w_do_pop);
    assign dout_o    = r_mem[r_rd_ptr];

    // Storage array; contents need no reset because the count gates reads.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din_i;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (PW + 1)'(1);
                2'b01:   r_count <= r_count - (PW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/mem_write_arbiter.sv
// Arbitrates the system memory write port between the SPI debug FIFO and the CPU,
// decodes the winning address into target write enables and owns the CPU reset bit.
module mem_write_arbiter
    import mem_map_pkg::*;
#(
    parameter int unsigned AWIDTH       = 16,
    parameter int unsigned DWIDTH       = 16,
    parameter int unsigned DBG_DEPTH    = 4,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dbg_wr_i,
    input  logic [AWIDTH-1:0] dbg_waddr_i,
    input  logic [DWIDTH-1:0] dbg_wdata_i,
    output logic              dbg_overflow_o,
    input  logic              cpu_wr_i,
    input  logic [AWIDTH-1:0] cpu_waddr_i,
    input  logic [DWIDTH-1:0] cpu_wdata_i,
    output logic              cpu_wait_o,
    output logic              we_o,
    output logic [AWIDTH-1:0] waddr_o,
    output logic [DWIDTH-1:0] wdata_o,
    output logic [1:0]        sram_we_o,
    output logic              vram_we_o,
    output logic              ctrl_we_o,
    output logic              cpu_reset_o
);

    localparam int unsigned STW = $clog2(STARVE_LIMIT + 1);
    localparam logic [STW-1:0] STARVE_MAX = STW'(STARVE_LIMIT);

    logic [AWIDTH+DWIDTH-1:0] w_fifo_dout;
    logic [AWIDTH-1:0]        w_fifo_addr;
    logic [DWIDTH-1:0]        w_fifo_data;
    logic                     w_fifo_full;
    logic                     w_fifo_empty;
    logic                     w_push;
    logic                     w_dbg_pick;
    grant_e                   w_grant;
    logic [AWIDTH-1:0]        w_gnt_addr;
    logic [DWIDTH-1:0]        w_gnt_data;
    logic [1:0]               w_sram_we;
    logic                     w_vram_we;
    logic                     w_ctrl_we;

    logic [STW-1:0]           r_starve;
    logic                     r_we;
    logic [AWIDTH-1:0]        r_waddr;
    logic [DWIDTH-1:0]        r_wdata;
    logic [1:0]               r_sram_we;
    logic                     r_vram_we;
    logic                     r_ctrl_we;
    logic                     r_overflow;
    logic                     r_cpu_reset;

    assign {w_fifo_addr, w_fifo_data} = w_fifo_dout;

    // Debug writes cannot stall: push unless the FIFO is full and not draining.
    assign w_push = dbg_wr_i & (~w_fifo_full | w_dbg_pick);

    sync_fifo #(
        .WIDTH (AWIDTH + DWIDTH),
        .DEPTH (DBG_DEPTH)
    ) u_dbg_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (w_push),
        .pop_i   (w_dbg_pick),
        .din_i   ({dbg_waddr_i, dbg_wdata_i}),
        .dout_o  (w_fifo_dout),
        .full_o  (w_fifo_full),
        .empty_o (w_fifo_empty)
    );

    // Grant decision: debug wins unless the CPU has waited through STARVE_LIMIT debug grants.
    always_comb begin
        w_dbg_pick = ~w_fifo_empty & (~cpu_wr_i | (r_starve < STARVE_MAX));
        w_grant    = GntNone;
        w_gnt_addr = cpu_waddr_i;
        w_gnt_data = cpu_wdata_i;
        if (w_dbg_pick) begin
            w_grant    = GntDbg;
            w_gnt_addr = w_fifo_addr;
            w_gnt_data = w_fifo_data;
        end else if (cpu_wr_i) begin
            w_grant = GntCpu;
        end
    end

    assign cpu_wait_o = cpu_wr_i & (w_grant != GntCpu);

    // Target decode of the granted address; unknown regions enable no target.
    always_comb begin
        w_sram_we = '0;
        w_vram_we = 1'b0;
        w_ctrl_we = 1'b0;
        if (w_grant != GntNone) begin
            unique case (w_gnt_addr[REGION_MSB:REGION_LSB])
                REGION_SRAM: w_sram_we[w_gnt_addr[BANK_SEL_BIT]] = 1'b1;
                REGION_VRAM: w_vram_we = 1'b1;
                REGION_CTRL: w_ctrl_we = 1'b1;
                default:     ;
            endcase
        end
    end

    // Starve counter: counts debug grants taken while the CPU is waiting.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_starve <= '0;
        end else if (~cpu_wr_i || (w_grant == GntCpu)) begin
            r_starve <= '0;
        end else if ((w_grant == GntDbg) && (r_starve != STARVE_MAX)) begin
            r_starve <= r_starve + STW'(1);
        end
    end

    // Registered write port and decoded enables; address/data hold when idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_we      <= 1'b0;
            r_waddr   <= '0;
            r_wdata   <= '0;
            r_sram_we <= '0;
            r_vram_we <= 1'b0;
            r_ctrl_we <= 1'b0;
        end else begin
            r_we      <= (w_grant != GntNone);
            r_sram_we <= w_sram_we;
            r_vram_we <= w_vram_we;
            r_ctrl_we <= w_ctrl_we;
            if (w_grant != GntNone) begin
                r_waddr <= w_gnt_addr;
                r_wdata <= w_gnt_data;
            end
        end
    end

    // Sticky overflow flag and the CPU reset control bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow  <= 1'b0;
            r_cpu_reset <= 1'b0;
        end else begin
            if (dbg_wr_i && !w_push) r_overflow <= 1'b1;
            if (r_ctrl_we) r_cpu_reset <= r_wdata[CTRL_RESET_BIT];
        end
    end

    assign we_o           = r_we;
    assign waddr_o        = r_waddr;
    assign wdata_o        = r_wdata;
    assign sram_we_o      = r_sram_we;
    assign vram_we_o      = r_vram_we;
    assign ctrl_we_o      = r_ctrl_we;
    assign dbg_overflow_o = r_overflow;
    assign cpu_reset_o    = r_cpu_reset;

endmodule
